// File: rtl/bus_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_cycle_ctrl_pkg
// Purpose : Shared definitions for the bus cycle controller.
//           - Datapath enable bit indices (IENB_*)
//           - Instruction-info field positions (INST_*)
//           - T-state encoding used by the sequencer
// Rev     : 1.0  initial release
// ============================================================================
package bus_cycle_ctrl_pkg;

    // Bit positions inside the ienb bus driven to the datapath
    localparam int IENB_RRD = 0;
    localparam int IENB_RWR = 1;
    localparam int IENB_COD = 2;
    localparam int IENB_DAT = 3;
    localparam int IENB_PC  = 4;
    localparam int IENB_PD  = 5;
    localparam int IENB_NXT = 6;
    localparam int IENB_USED = 7;

    // Field positions inside the decoded instruction info bus
    localparam int INST_GO6       = 0;
    localparam int INST_HLT       = 2;
    localparam int INST_DIO       = 3;
    localparam int INST_CYCGO_LSB = 4;
    localparam int INST_CYCRW_LSB = 8;
    localparam int INST_CYCCD_LSB = 12;
    localparam int INST_FLD_W     = 4;

    // The encoding of T1..T6 equals the reported T-state number, so the
    // tstate output can be taken straight from the state value.
    typedef enum logic [2:0] {
        TS_RESET = 3'd0,
        TS_T1    = 3'd1,
        TS_T2    = 3'd2,
        TS_T3    = 3'd3,
        TS_T4    = 3'd4,
        TS_T5    = 3'd5,
        TS_T6    = 3'd6,
        TS_HALT  = 3'd7
    } tstate_e;

endpackage
`default_nettype wire

// File: rtl/bus_cycle_ctrl_cyc_count.sv
`default_nettype none
// ============================================================================
// Module  : cyc_count
// Purpose : Converts the cycgo thermometer field into the number of extra
//           machine cycles: index of the highest set bit plus one.
// Ports   : cycgo_i  [3:0]  thermometer field from the instruction info
//           n_o      [2:0]  extra machine cycle count, 0..4
// Rev     : 1.0  initial release
// ============================================================================
module cyc_count (
    input  logic [3:0] cycgo_i,
    output logic [2:0] n_o
);

    // Scanning upward lets the highest set bit win, so a malformed
    // (non-thermometer) pattern still yields a well-defined count.
    always_comb begin
        n_o = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (cycgo_i[i]) begin
                n_o = 3'(i + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bus_cycle_ctrl
// Purpose : Machine-cycle / T-state sequencer for a simple CPU bus. Runs the
//           M1 opcode fetch (T1..T4, optionally T5/T6), then up to four extra
//           read/write machine cycles described by the latched instruction
//           info, or parks in HALT.
// Ports   : clk      system clock, rising edge
//           rst      asynchronous active-high reset
//           chk_i    decoded instruction info (GO6, HLT, DIO, cycgo/rw/cd)
//           ready    memory/IO ready, low inserts T2 wait states
//           ienb     datapath enables (RRD RWR COD DAT PC_ PD_ NXT)
//           ale      address latch strobe, T1 of every machine cycle
//           mem_rd   bus read strobe
//           mem_wr   bus write strobe
//           io_m     IO bus cycle indicator
//           halt     HALT state indicator
//           mcyc     machine cycle number, 1..5
//           tstate   T-state number, 1..6
// Config  : WAIT_STATE_EN  when defined, ready=0 holds T2; otherwise T2 is
//           always a single clock and ready is ignored.
// Rev     : 1.0  initial release
// ============================================================================
module bus_cycle_ctrl
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int IENBSIZE = 7,
    parameter int INSTSIZE = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTSIZE-1:0] chk_i,
    input  logic                ready,
    output logic [IENBSIZE-1:0] ienb,
    output logic                ale,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                io_m,
    output logic                halt,
    output logic [2:0]          mcyc,
    output logic [2:0]          tstate
);

    // ------------------------------------------------------------------
    // Ready qualification
    // ------------------------------------------------------------------
    logic ready_w;
`ifdef WAIT_STATE_EN
    assign ready_w = ready;
`else
    logic unused_ready_w;
    assign ready_w        = 1'b1;
    assign unused_ready_w = ready;
`endif

    // Bits of chk_i outside the decoded fields have no function here
    logic unused_chk_w;
    assign unused_chk_w = ^chk_i;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    tstate_e    state_q, state_d;
    logic [2:0] mcyc_q, mcyc_d;

    // Instruction info latched at the M1 T3->T4 edge
    logic       go6_q,   go6_d;
    logic       hlt_q,   hlt_d;
    logic       dio_q,   dio_d;
    logic [3:0] cycrw_q, cycrw_d;
    logic [3:0] cyccd_q, cyccd_d;
    logic [2:0] n_q,     n_d;
    logic [2:0] n_new_w;
    logic       latch_w;

    cyc_count u_cyc_count (
        .cycgo_i (chk_i[INST_CYCGO_LSB +: INST_FLD_W]),
        .n_o     (n_new_w)
    );

    assign latch_w = (state_q == TS_T3) && (mcyc_q == 3'd1);

    // Next values of the latched fields; outputs are built from these so the
    // T4 enables already reflect the instruction being latched this edge.
    always_comb begin
        go6_d   = go6_q;
        hlt_d   = hlt_q;
        dio_d   = dio_q;
        cycrw_d = cycrw_q;
        cyccd_d = cyccd_q;
        n_d     = n_q;
        if (latch_w) begin
            go6_d   = chk_i[INST_GO6];
            hlt_d   = chk_i[INST_HLT];
            dio_d   = chk_i[INST_DIO];
            cycrw_d = chk_i[INST_CYCRW_LSB +: INST_FLD_W];
            cyccd_d = chk_i[INST_CYCCD_LSB +: INST_FLD_W];
            n_d     = n_new_w;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        mcyc_d  = mcyc_q;
        case (state_q)
            TS_RESET: begin
                state_d = TS_T1;
                mcyc_d  = 3'd1;
            end
            TS_T1: state_d = TS_T2;
            TS_T2: begin
                if (ready_w) begin
                    state_d = TS_T3;
                end
            end
            TS_T3: begin
                if (mcyc_q == 3'd1) begin
                    state_d = TS_T4;
                end else begin
                    state_d = TS_T1;
                    // Extra cycle k = mcyc-2 is the last one when k == N-1
                    mcyc_d  = (mcyc_q == n_q + 3'd1) ? 3'd1 : mcyc_q + 3'd1;
                end
            end
            TS_T4: begin
                if (hlt_q) begin
                    state_d = TS_HALT;
                end else if (go6_q) begin
                    state_d = TS_T5;
                end else begin
                    state_d = TS_T1;
                    mcyc_d  = (n_q != 3'd0) ? 3'd2 : 3'd1;
                end
            end
            TS_T5: state_d = TS_T6;
            TS_T6: begin
                state_d = TS_T1;
                mcyc_d  = (n_q != 3'd0) ? 3'd2 : 3'd1;
            end
            TS_HALT: state_d = TS_HALT;
            default: begin
                state_d = TS_T1;
                mcyc_d  = 3'd1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state; the results land in registers so
    // every output is aligned with the state it describes.
    // ------------------------------------------------------------------
    logic [IENB_USED-1:0] ienb_d;
    logic                 ale_d, mem_rd_d, mem_wr_d, io_m_d, halt_d;
    logic [2:0]           tstate_d;
    logic [1:0]           k_w;
    logic                 in_t23_w;

    assign k_w      = 2'(mcyc_d - 3'd2);
    assign in_t23_w = (state_d == TS_T2) || (state_d == TS_T3);

    always_comb begin
        ienb_d   = '0;
        ale_d    = 1'b0;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        io_m_d   = 1'b0;
        halt_d   = 1'b0;
        tstate_d = 3'(state_d);
        if (state_d == TS_HALT) begin
            halt_d   = 1'b1;
            // HALT is always entered from T4
            tstate_d = 3'd4;
        end else if (mcyc_d == 3'd1) begin
            case (state_d)
                TS_T1: ale_d = 1'b1;
                TS_T2: mem_rd_d = 1'b1;
                TS_T3: begin
                    mem_rd_d         = 1'b1;
                    ienb_d[IENB_COD] = 1'b1;
                    ienb_d[IENB_PC]  = 1'b1;
                end
                TS_T4: begin
                    // Register-to-register move completes in T4
                    if (n_d == 3'd0 && !hlt_d) begin
                        ienb_d[IENB_RRD] = 1'b1;
                        ienb_d[IENB_RWR] = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            ienb_d[IENB_PD]  = cyccd_d[k_w];
            ienb_d[IENB_NXT] = ~k_w[0];
            io_m_d           = dio_d && (mcyc_d == n_d + 3'd1);
            ale_d            = (state_d == TS_T1);
            if (cycrw_d[k_w]) begin
                ienb_d[IENB_RRD] = 1'b1;
                mem_wr_d         = in_t23_w;
            end else begin
                mem_rd_d = in_t23_w;
                if (state_d == TS_T3) begin
                    ienb_d[IENB_RWR] = 1'b1;
                    ienb_d[IENB_PC]  = ~cyccd_d[k_w];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [IENBSIZE-1:0] ienb_q;
    logic                ale_q, mem_rd_q, mem_wr_q, io_m_q, halt_q;
    logic [2:0]          mcyc_out_q, tstate_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TS_RESET;
            mcyc_q     <= 3'd1;
            go6_q      <= 1'b0;
            hlt_q      <= 1'b0;
            dio_q      <= 1'b0;
            cycrw_q    <= '0;
            cyccd_q    <= '0;
            n_q        <= '0;
            ienb_q     <= '0;
            ale_q      <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            io_m_q     <= 1'b0;
            halt_q     <= 1'b0;
            mcyc_out_q <= 3'd1;
            tstate_q   <= 3'd1;
        end else begin
            state_q    <= state_d;
            mcyc_q     <= mcyc_d;
            go6_q      <= go6_d;
            hlt_q      <= hlt_d;
            dio_q      <= dio_d;
            cycrw_q    <= cycrw_d;
            cyccd_q    <= cyccd_d;
            n_q        <= n_d;
            ienb_q     <= IENBSIZE'(ienb_d);
            ale_q      <= ale_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            io_m_q     <= io_m_d;
            halt_q     <= halt_d;
            mcyc_out_q <= mcyc_d;
            tstate_q   <= tstate_d;
        end
    end

    assign ienb   = ienb_q;
    assign ale    = ale_q;
    assign mem_rd = mem_rd_q;
    assign mem_wr = mem_wr_q;
    assign io_m   = io_m_q;
    assign halt   = halt_q;
    assign mcyc   = mcyc_out_q;
    assign tstate = tstate_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_cycle_ctrl
// Purpose : Self-checking bench for bus_cycle_ctrl. Expected per-clock output
//           snapshots are queued as each instruction is set up and compared
//           one per clock as the controller steps through its states.
// Rev     : 1.0  initial release
// ============================================================================
module tb_bus_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] chk_i;
    logic        ready;
    logic [6:0]  ienb;
    logic        ale, mem_rd, mem_wr, io_m, halt;
    logic [2:0]  mcyc, tstate;

    int    checks   = 0;
    int    failures = 0;
    int    step     = 0;
    string tag      = "init";

    // flag vector order: {ale, mem_rd, mem_wr, io_m, halt}
    localparam logic [4:0] F_ALE = 5'b10000;
    localparam logic [4:0] F_RD  = 5'b01000;
    localparam logic [4:0] F_WR  = 5'b00100;
    localparam logic [4:0] F_IO  = 5'b00010;
    localparam logic [4:0] F_HLT = 5'b00001;

    typedef struct packed {
        logic [6:0] ie;
        logic [4:0] fl;
        logic [2:0] mc;
        logic [2:0] ts;
        logic       mt;   // compare mcyc/tstate
        logic       rdy;  // ready driven during this state
    } exp_t;

    exp_t sb[$];

    bus_cycle_ctrl #(.IENBSIZE(7), .INSTSIZE(17)) dut (
        .clk    (clk),
        .rst    (rst),
        .chk_i  (chk_i),
        .ready  (ready),
        .ienb   (ienb),
        .ale    (ale),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .io_m   (io_m),
        .halt   (halt),
        .mcyc   (mcyc),
        .tstate (tstate)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] ie, input logic [4:0] fl,
                                input logic [2:0] mc, input logic [2:0] ts,
                                input logic rdy = 1'b1, input logic mt = 1'b1);
        exp_t e;
        e.ie = ie; e.fl = fl; e.mc = mc; e.ts = ts; e.mt = mt; e.rdy = rdy;
        return e;
    endfunction

    task automatic p(input logic [6:0] ie, input logic [4:0] fl,
                     input logic [2:0] mc, input logic [2:0] ts,
                     input logic rdy = 1'b1, input logic mt = 1'b1);
        sb.push_back(mk(ie, fl, mc, ts, rdy, mt));
    endtask

    // Standard M1 fetch T1..T4 with the given T4 enables
    task automatic m1(input logic [6:0] t4_ienb);
        p(7'h00, F_ALE, 3'd1, 3'd1);
        p(7'h00, F_RD,  3'd1, 3'd2);
        p(7'h14, F_RD,  3'd1, 3'd3);
        p(t4_ienb, 5'b0, 3'd1, 3'd4);
    endtask

    task automatic compare(input exp_t e);
        logic [11:0] got;
        got = {ienb, ale, mem_rd, mem_wr, io_m, halt};
        step++;
        checks++;
        assert (got === {e.ie, e.fl}) else begin
            failures++;
            $error("FAIL %s step %0d: ienb=%h flags=%b, expected ienb=%h flags=%b",
                   tag, step, got[11:5], got[4:0], e.ie, e.fl);
        end
        if (e.mt) begin
            checks++;
            assert ({mcyc, tstate} === {e.mc, e.ts}) else begin
                failures++;
                $error("FAIL %s step %0d: mcyc=%0d tstate=%0d, expected mcyc=%0d tstate=%0d",
                       tag, step, mcyc, tstate, e.mc, e.ts);
            end
        end
    endtask

    // Drain the scoreboard one clock per entry (bounded by its length)
    task automatic run();
        exp_t e;
        while (sb.size() > 0) begin
            @(posedge clk);
            @(negedge clk);
            e = sb.pop_front();
            compare(e);
            ready = e.rdy;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        ready = 1'b1;
        chk_i = 17'h0;
        @(negedge clk);
        @(negedge clk);
        tag = "reset";
        compare(mk(7'h00, 5'b0, 3'd1, 3'd1));
        rst = 1'b0;

        // Register move: 4 clocks, T3 0x14, T4 0x03
        tag = "regmove";
        m1(7'h03);
        run();

        // One read cycle, cyccd=0 -> PC_ in T3
        tag = "read1";
        chk_i = 17'h00010;
        m1(7'h00);
        p(7'h40, F_ALE, 3'd2, 3'd1);
        p(7'h40, F_RD,  3'd2, 3'd2);
        p(7'h52, F_RD,  3'd2, 3'd3);
        run();

        // One write cycle, cyccd=1 -> PD_, never PC_
        tag = "write1";
        chk_i = 17'h01110;
        m1(7'h00);
        p(7'h61, F_ALE, 3'd2, 3'd1);
        p(7'h61, F_WR,  3'd2, 3'd2);
        p(7'h61, F_WR,  3'd2, 3'd3);
        run();

        // GO6 + DIO, read then write; io_m on the last cycle only
        tag = "go6_dio";
        chk_i = 17'h02239;
        m1(7'h00);
        p(7'h00, 5'b0, 3'd1, 3'd5);
        p(7'h00, 5'b0, 3'd1, 3'd6);
        p(7'h40, F_ALE, 3'd2, 3'd1);
        p(7'h40, F_RD,  3'd2, 3'd2);
        p(7'h52, F_RD,  3'd2, 3'd3);
        p(7'h21, F_ALE | F_IO, 3'd3, 3'd1);
        p(7'h21, F_WR  | F_IO, 3'd3, 3'd2);
        p(7'h21, F_WR  | F_IO, 3'd3, 3'd3);
        run();

        // cycgo=1000 -> four read cycles M2..M5, NXT alternating
        tag = "n4";
        chk_i = 17'h00080;
        m1(7'h00);
        for (int k = 0; k < 4; k++) begin
            logic [6:0] nxt;
            nxt = (k % 2 == 0) ? 7'h40 : 7'h00;
            p(nxt,         F_ALE, 3'(k + 2), 3'd1);
            p(nxt,         F_RD,  3'(k + 2), 3'd2);
            p(nxt | 7'h12, F_RD,  3'(k + 2), 3'd3);
        end
        run();

        // ready low in M1 T2
        tag = "wait";
        chk_i = 17'h0;
        p(7'h00, F_ALE, 3'd1, 3'd1);
`ifdef WAIT_STATE_EN
        p(7'h00, F_RD, 3'd1, 3'd2, 1'b0);
        p(7'h00, F_RD, 3'd1, 3'd2, 1'b0);
        p(7'h00, F_RD, 3'd1, 3'd2, 1'b0);
        p(7'h00, F_RD, 3'd1, 3'd2, 1'b1);
`else
        p(7'h00, F_RD, 3'd1, 3'd2, 1'b0);
`endif
        p(7'h14, F_RD,  3'd1, 3'd3);
        p(7'h03, 5'b0,  3'd1, 3'd4);
        run();

        // Reset in the middle of M2
        tag = "rst_mid";
        chk_i = 17'h00010;
        m1(7'h00);
        p(7'h40, F_ALE, 3'd2, 3'd1);
        run();
        #2 rst = 1'b1;
        #1 compare(mk(7'h00, 5'b0, 3'd1, 3'd1));
        @(negedge clk);
        compare(mk(7'h00, 5'b0, 3'd1, 3'd1));
        rst   = 1'b0;
        chk_i = 17'h0;
        tag = "rst_after";
        m1(7'h03);
        run();

        // HLT: halt for 100 clocks, then reset pulse
        tag = "halt";
        chk_i = 17'h00004;
        m1(7'h00);
        repeat (100) p(7'h00, F_HLT, 3'd0, 3'd0, 1'b1, 1'b0);
        run();
        #2 rst = 1'b1;
        #1 compare(mk(7'h00, 5'b0, 3'd1, 3'd1));
        @(negedge clk);
        rst   = 1'b0;
        chk_i = 17'h0;
        tag = "halt_exit";
        m1(7'h03);
        run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_cycle_ctrl.md
BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

Interface
REQ-001 SHALL have parameter IENBSIZE, default 7, width of the enable bus sent to the register/ALU datapath.
REQ-002 SHALL have parameter INSTSIZE, default 17, width of the decoded-instruction info bus from the datapath.
REQ-003 SHALL have port clk, input, 1, single system clock, rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port chk_i, input, INSTSIZE, instruction info:
- [0] GO6
- [2] HLT
- [3] DIO
- [7:4] cycgo
- [11:8] cycrw
- [15:12] cyccd
REQ-006 SHALL have port ready, input, 1, memory/IO ready; low inserts wait states.
REQ-007 SHALL have port ienb, output, IENBSIZE, datapath enables:
- 0 RRD, 1 RWR, 2 COD, 3 DAT, 4 PC_, 5 PD_, 6 NXT.
REQ-008 SHALL have port ale, output, 1, address latch strobe.
REQ-009 SHALL have port mem_rd, output, 1, bus read strobe.
REQ-010 SHALL have port mem_wr, output, 1, bus write strobe.
REQ-011 SHALL have port io_m, output, 1, high during an IO bus cycle.
REQ-012 SHALL have port halt, output, 1, high in HALT state.
REQ-013 SHALL have port mcyc, output, 3, current machine cycle, 1..5.
REQ-014 SHALL have port tstate, output, 3, current T-state, 1..6.

Function
REQ-015 SHALL sequence machine cycles M1..M5, each built from states T1, T2, T3; M1 adds T4, plus T5/T6 when GO6.
REQ-016 SHALL assert ale in T1 of every machine cycle, for exactly one clock.
REQ-017 M1 opcode fetch SHALL behave as follows:
- T1: PD_=0.
- T2: mem_rd=1.
- T3: mem_rd=1, COD=1, PC_=1.
REQ-018 SHALL register chk_i at the T3-to-T4 edge of M1 and ignore chk_i at all other times.
REQ-019 SHALL set the extra cycle count N to the index of the highest set bit of cycgo plus one (0000->0, 0001->1, 0011->2, 0111->3, 1111->4).
REQ-020 In T4, if N=0 and HLT=0, SHALL assert RRD|RWR for one clock.
REQ-021 SHALL enter T5 and T6 after T4 when GO6=1, with ienb=0 in both states.
REQ-022 After the last M1 state, SHALL go to M2 T1 when N>0, otherwise to M1 T1.
REQ-023 For extra cycle k (0..N-1, machine cycle M(k+2)), SHALL drive PD_=cyccd[k] and NXT=~k[0] through all its T-states.
REQ-024 Read cycle (cycrw[k]=0) SHALL behave as follows:
- mem_rd=1 in T2 and T3.
- RWR=1 in T3.
- PC_=1 in T3 when cyccd[k]=0.
REQ-025 Write cycle (cycrw[k]=1) SHALL behave as follows:
- RRD=1 in T1..T3.
- mem_wr=1 in T2 and T3.
- No PC_.
REQ-026 SHALL assert io_m throughout the last extra cycle when DIO=1.
REQ-027 SHALL hold T2 while ready=0, keeping strobes and ienb unchanged; T3 follows the first T2 clock with ready=1.
REQ-028 If HLT=1 at T4, SHALL enter HALT: halt=1, ienb=0, all strobes 0, until rst.
REQ-029 SHALL keep mem_rd and mem_wr mutually exclusive, and SHALL assert COD only in M1 T3.
REQ-030 SHALL register all outputs; no combinational path from chk_i or ready to any output.

Reset
REQ-031 While rst=1, SHALL force state M1 T1 and all outputs to 0, except mcyc=1 and tstate=1.
REQ-032 Reset asserted mid-cycle SHALL abort the cycle immediately; the first clock after release SHALL be M1 T1 with ale=1.

Configuration
REQ-033 Macro WAIT_STATE_EN defined SHALL honour ready as in REQ-027.
REQ-034 Macro WAIT_STATE_EN undefined SHALL ignore ready, with T2 always exactly one clock.

Structure
REQ-035 SHALL take the IENB_* bit indices, the INST_* field positions and the state encoding from the shared core package.
REQ-036 SHALL place the cycgo-to-N thermometer decode in one sub-module, cyc_count.

Verification
REQ-037 Reset check: rst=1 mid-M2 -> all outputs 0; after release, first clock ale=1, tstate=1, mcyc=1.
REQ-038 chk_i=0 (register move) -> M1 T3 ienb=0x14, T4 ienb=0x03, next clock M1 T1; 4 clocks total.
REQ-039 cycgo=0001, cycrw=0000, cyccd=0000 -> M2 T3 ienb=0x52 with mem_rd=1; then M1 T1.
REQ-040 cycgo=0001, cycrw=0001, cyccd=0001 -> M2 ienb=0x61 through T1..T3; mem_wr=1 in T2/T3; PC_ never set.
REQ-041 ready=0 for 3 clocks in M1 T2 -> T2 lasts 4 clocks with mem_rd held (WAIT_STATE_EN); without the macro T2 lasts 1 clock.
REQ-042 chk_i[2]=1 -> halt=1 after T4 and ienb stays 0 for 100 clocks; rst pulse returns to M1 T1.
